// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encodings and flag bundle for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic overflow;
      logic carry;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one bit of B per cycle, WIDTH iterations.
// The first iteration is folded into the start cycle; done pulses on the last one.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int SHW = $clog2(WIDTH);

   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   // next-state for one shift-add step
   always_comb begin
      active_d = active_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = {{(SHW-1){1'b0}}, 1'b1};
         prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
         mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
         mplier_d = {1'b0, b[WIDTH-1:1]};
      end else if (active_q) begin
         prod_d   = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
         mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
         cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
         if (cnt_q == SHW'(WIDTH-1)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end else begin
            active_d = 1'b1;
         end
      end else begin
         active_d = 1'b0;
      end
   end

   // iteration registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         active_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= {SHW{1'b0}};
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         prod_q   <= {(2*WIDTH){1'b0}};
      end else begin
         active_q <= active_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and registered result/flags.
// Define ALU_MUL_EN to build in the iterative multiplier (op 1011) and the BUSY state.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic [3:0]        ALUop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  Result,
   output logic              Overflow,
   output logic              CarryOut,
   output logic              Zero
);

   localparam int SHW = $clog2(WIDTH);

   logic [1:0]        state_q, state_d;
   logic [WIDTH-1:0]  result_q, result_d;
   alu_flags_t        flags_q, flags_d;
   logic              out_valid_q, out_valid_d;

   logic              sub_s, add_ovf_s, is_mul_s, accept_s;
   logic [WIDTH-1:0]  b_eff_s, alu_res_s;
   logic [WIDTH:0]    sum_s;
   logic [SHW-1:0]    shamt_s;
   logic [1:0]        op_state_s;
   alu_flags_t        alu_flags_s;

`ifdef ALU_MUL_EN
   logic              mul_done_s;
   logic [2*WIDTH-1:0] mul_prod_s;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .resetn  (resetn),
      .start   (accept_s && is_mul_s),
      .a       (A),
      .b       (B),
      .done    (mul_done_s),
      .product (mul_prod_s)
   );
   assign is_mul_s = (ALUop == OP_MUL);
`else
   assign is_mul_s = 1'b0;
`endif

   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept_s   = in_valid && in_ready;
   assign op_state_s = is_mul_s ? ST_BUSY : ST_DONE;
   assign shamt_s    = B[SHW-1:0];

   // shared adder: carry into the MSB xor carry out gives signed overflow
   always_comb begin
      sub_s     = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
      b_eff_s   = sub_s ? ~B : B;
      sum_s     = {1'b0, A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
      add_ovf_s = (A[WIDTH-1] ^ b_eff_s[WIDTH-1] ^ sum_s[WIDTH-1]) ^ sum_s[WIDTH];
   end

   // single-cycle result and flags
   always_comb begin
      alu_res_s   = {WIDTH{1'b0}};
      alu_flags_s = 2'b00;
      case (ALUop)
         OP_AND:  alu_res_s = A & B;
         OP_OR:   alu_res_s = A | B;
         OP_XOR:  alu_res_s = A ^ B;
         OP_NOR:  alu_res_s = ~(A | B);
         OP_ADD: begin
            alu_res_s            = sum_s[WIDTH-1:0];
            alu_flags_s.overflow = add_ovf_s;
            alu_flags_s.carry    = sum_s[WIDTH];
         end
         OP_SUB: begin
            alu_res_s            = sum_s[WIDTH-1:0];
            alu_flags_s.overflow = add_ovf_s;
            alu_flags_s.carry    = ~sum_s[WIDTH];
         end
         OP_SLT: begin
            alu_res_s            = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
            alu_flags_s.overflow = add_ovf_s;
            alu_flags_s.carry    = ~sum_s[WIDTH];
         end
         OP_SLTU: begin
            alu_res_s            = {{(WIDTH-1){1'b0}}, ~sum_s[WIDTH]};
            alu_flags_s.overflow = add_ovf_s;
            alu_flags_s.carry    = ~sum_s[WIDTH];
         end
         OP_SLL:  alu_res_s = A << shamt_s;
         OP_SRL:  alu_res_s = A >> shamt_s;
         OP_SRA:  alu_res_s = $signed(A) >>> shamt_s;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // handshake FSM and output register update
   always_comb begin
      state_d = state_q;
      if (accept_s && !is_mul_s) begin
         result_d = alu_res_s;
         flags_d  = alu_flags_s;
      end
`ifdef ALU_MUL_EN
      else if ((state_q == ST_BUSY) && mul_done_s) begin
         result_d         = mul_prod_s[WIDTH-1:0];
         flags_d.overflow = 1'b0;
         flags_d.carry    = |mul_prod_s[2*WIDTH-1:WIDTH];
      end
`endif
      else begin
         result_d = result_q;
         flags_d  = flags_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = op_state_s;
            else          state_d = ST_IDLE;
         end
`ifdef ALU_MUL_EN
         ST_BUSY: begin
            if (mul_done_s) state_d = ST_DONE;
            else            state_d = ST_BUSY;
         end
`endif
         ST_DONE: begin
            if (!out_ready)    state_d = ST_DONE;
            else if (accept_s) state_d = op_state_s;
            else               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      out_valid_d = (state_d == ST_DONE);
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         result_q    <= {WIDTH{1'b0}};
         flags_q     <= 2'b00;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign Overflow  = flags_q.overflow;
   assign CarryOut  = flags_q.carry;
   assign Zero      = (result_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_mc.sv
// Randomised bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          resetn, in_valid, out_ready;
   logic [W-1:0]  a, b;
   logic [3:0]    op;
   logic          in_ready, out_valid, ovf, cout, zero;
   logic [W-1:0]  res;

   int errors = 0;
   int checks = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .ALUop(op), .out_valid(out_valid), .out_ready(out_ready),
      .Result(res), .Overflow(ovf), .CarryOut(cout), .Zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: signed/unsigned arithmetic on wide integers
   function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic v, output logic c);
      longint sx, sy, sd;
      logic [32:0] u;
      logic [31:0] d;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      d  = x - y;
      sd = sx - sy;
      r = 32'd0; v = 1'b0; c = 1'b0;
      case (o)
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h3: r = x ^ y;
         4'h4: r = ~(x | y);
         4'h2: begin
            u = {1'b0, x} + {1'b0, y};
            r = u[31:0];
            c = u[32];
            v = ((sx + sy) != longint'($signed(u[31:0])));
         end
         4'h6, 4'h7, 4'h5: begin
            v = (sd != longint'($signed(d)));
            c = (x < y);
            if (o == 4'h6)      r = d;
            else if (o == 4'h7) r = {31'd0, (sx < sy)};
            else                r = {31'd0, (x < y)};
         end
         4'h8: r = x << y[4:0];
         4'h9: r = x >> y[4:0];
         4'hA: r = 32'($signed(x) >>> y[4:0]);
`ifdef ALU_MUL_EN
         4'hB: begin
            p = 64'(x) * 64'(y);
            r = p[31:0];
            c = |p[63:32];
         end
`endif
         default: r = 32'd0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [3:0] o);
`ifdef ALU_MUL_EN
      return (o == 4'hB) ? W + 1 : 1;
`else
      return (o == 4'hB) ? 1 : 1;
`endif
   endfunction

   // one transaction, entered and left at a falling edge
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] er;
      logic ev, ec;
      int lat;
      bit seen;
      model(o, x, y, er, ev, ec);
      check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
      lat = 1; seen = 0;
      while (!seen && lat <= 40) begin
         if (out_valid) seen = 1;
         else begin
            check({tag, "_busy_inrdy"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat(o)));
      check({tag, "_res"}, 64'(res), 64'(er));
      check({tag, "_ovf"}, 64'(ovf), 64'(ev));
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check({tag, "_zero"}, 64'(zero), 64'(er == 32'd0));
      @(negedge clk);
      check({tag, "_retire"}, 64'(out_valid), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ov"}, 64'(out_valid), 64'd0);
      check({tag, "_res"}, 64'(res), 64'd0);
      check({tag, "_flags"}, {62'd0, ovf, cout}, 64'd0);
      check({tag, "_zero"}, 64'(zero), 64'd1);
   endtask

   initial begin
      logic [31:0] er, ex[4];
      logic ev, ec;
      int cnt;
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; op = 4'd0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");
      check("reset_inrdy", 64'(in_ready), 64'd1);

      run_op(4'h2, 32'h7FFFFFFF, 32'h00000001, "add_ovf");
      run_op(4'h6, 32'h00000003, 32'h00000005, "sub");
      run_op(4'h7, 32'h00000003, 32'h00000005, "slt");
      run_op(4'h5, 32'hFFFFFFFF, 32'h00000001, "sltu");
      run_op(4'hA, 32'h80000000, 32'h0000001F, "sra");
      run_op(4'h8, 32'h00000001, 32'h00000024, "sll");
      run_op(4'hB, 32'h0000FFFF, 32'h00010001, "mul1");
      run_op(4'hB, 32'h80000000, 32'h80000000, "mul2");
      run_op(4'hF, 32'h12345678, 32'h9ABCDEF0, "illegal");

      // backpressure: result held, no accept while consumer stalls
      model(4'h2, 32'h00001111, 32'h00002222, er, ev, ec);
      op = 4'h2; a = 32'h00001111; b = 32'h00002222; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      op = 4'h6; a = 32'hDEADBEEF; b = 32'h1;
      repeat (5) begin
         check("bp_ov", 64'(out_valid), 64'd1);
         check("bp_res", 64'(res), 64'(er));
         check("bp_inrdy", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom; op = 4'h2; in_valid = 1'b1; out_ready = 1'b1;
         model(4'h2, a, b, ex[i], ev, ec);
         @(posedge clk);
         @(negedge clk);
         check("stream_ov", 64'(out_valid), 64'd1);
         check("stream_res", 64'(res), 64'(ex[i]));
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_end", 64'(out_valid), 64'd0);

      // async reset while a result is held
      op = 4'h2; a = 32'hFFFFFFFF; b = 32'h00000002; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_cout", 64'(cout), 64'd1);
      resetn = 1'b0;
      #1;
      check_reset_vals("rst_done");
      @(negedge clk);
      resetn = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_done_inrdy", 64'(in_ready), 64'd1);

`ifdef ALU_MUL_EN
      // async reset in the middle of a multiply
      op = 4'hB; a = 32'h12345; b = 32'h6789; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_vals("rst_mul");
      @(negedge clk);
      resetn = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("rst_mul_no_ov", 64'(cnt), 64'd0);
`endif

      for (int i = 0; i < 150; i++) begin
         logic [31:0] x, y;
         x = $urandom; y = $urandom;
         if (i % 10 == 0) x = 32'h80000000;
         if (i % 7 == 0)  y = 32'($urandom_range(0, 3));
         run_op(4'($urandom_range(0, 15)), x, y, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
